// File: rtl/spi_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_ctrl_pkg
// Description : Shared definitions for the SPI register controller: command
//               opcodes, sequencer state encoding and frame-byte decode
//               helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package spi_ctrl_pkg;

    // Command opcodes carried in the first byte of a frame
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] OP_CLEAR = 8'h03;

    // Sequencer states with a fixed 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OPCODE  = 3'd1,
        ST_ADDR    = 3'd2,
        ST_WDATA   = 3'd3,
        ST_RDATA   = 3'd4,
        ST_DISCARD = 3'd5
    } state_t;

    // True when an address byte lies outside a bank of num_regs registers.
    // Compared at 32 bits so a 256-entry bank never flags an error.
    function automatic logic addr_out_of_range(input logic [7:0] addr_byte,
                                               input int         num_regs);
        return ({24'd0, addr_byte} >= 32'(num_regs));
    endfunction

endpackage : spi_ctrl_pkg
`default_nettype wire

// File: rtl/spi_reg_controller_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank
// Description : NUM_REGS x 8-bit register storage with a single write port,
//               a synchronous whole-bank clear, a combinational read mux and
//               a flattened view of every register.
// Ports       : clk, rst        - clock and synchronous active-high reset
//               clear           - zero every register on this edge
//               wr_en/wr_idx/   - write port (ignored while clear is high)
//               wr_data
//               rd_idx/rd_data  - combinational read port
//               regs_flat       - reg i at bits [8i+7:8i]
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank
    import spi_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_idx,
    input  logic [7:0]            wr_data,
    input  logic [ADDR_W-1:0]     rd_idx,
    output logic [7:0]            rd_data,
    output logic [8*NUM_REGS-1:0] regs_flat
);

    logic [7:0] r_regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else if (wr_en) begin
            r_regs[wr_idx] <= wr_data;
        end
    end

    assign rd_data = r_regs[rd_idx];

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
            assign regs_flat[8*g +: 8] = r_regs[g];
        end
    endgenerate

endmodule : reg_bank
`default_nettype wire

// File: rtl/spi_reg_controller.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_controller
// Description : Command sequencer between an SPI slave byte stream and a
//               register bank. Parses chip-select framed commands
//               (WRITE / READ / CLEAR), performs burst writes and burst
//               reads with a wrapping pointer, and flags protocol errors.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               frame_active     - synchronized chip select
//               byte_in/valid    - received byte and its one-cycle strobe
//               tx_byte/tx_load  - next byte to shift out and its pulse
//               regs_flat        - register bank, reg i at [8i+7:8i]
//               wr_strobe/addr   - one pulse per register write + index
//               busy             - sequencer not idle
//               cmd_error        - sticky protocol error
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_controller
    import spi_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_active,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic [7:0]            tx_byte,
    output logic                  tx_load,
    output logic [8*NUM_REGS-1:0] regs_flat,
    output logic                  wr_strobe,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic                  busy,
    output logic                  cmd_error
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic                r_is_read;
    logic [7:0]          r_tx_byte;
    logic                r_tx_load;
    logic                r_wr_strobe;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic                r_cmd_error;

    logic                w_byte_ok;
    logic [ADDR_W-1:0]   w_addr_idx;
    logic                w_addr_oob;
    logic [ADDR_W-1:0]   w_rd_idx;
    logic [7:0]          w_rd_data;
    logic                w_bank_we;
    logic                w_bank_clear;

    // A byte counts only while chip select is asserted in the same cycle
    assign w_byte_ok  = byte_valid && frame_active;
    assign w_addr_idx = byte_in[ADDR_W-1:0];
    assign w_addr_oob = addr_out_of_range(byte_in, NUM_REGS);

    // The first read of a burst uses the address byte arriving now; later
    // reads use the running pointer.
    assign w_rd_idx = (r_state == ST_ADDR) ? w_addr_idx : r_ptr;

    // Bank controls are decoded combinationally so the write/clear lands on
    // the same edge that consumes the byte.
    assign w_bank_we    = w_byte_ok && (r_state == ST_WDATA);
    assign w_bank_clear = w_byte_ok && (r_state == ST_OPCODE) && (byte_in == OP_CLEAR);

    reg_bank #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_reg_bank (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_bank_clear),
        .wr_en     (w_bank_we),
        .wr_idx    (r_ptr),
        .wr_data   (byte_in),
        .rd_idx    (w_rd_idx),
        .rd_data   (w_rd_data),
        .regs_flat (regs_flat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_is_read   <= 1'b0;
            r_tx_byte   <= 8'h00;
            r_tx_load   <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_cmd_error <= 1'b0;
        end else begin
            r_tx_load   <= 1'b0;
            r_wr_strobe <= 1'b0;

            if (!frame_active) begin
                // Chip select released: abandon whatever was in progress
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_OPCODE;
                    end

                    ST_OPCODE: begin
                        if (byte_valid) begin
                            case (byte_in)
                                OP_WRITE: begin
                                    r_is_read <= 1'b0;
                                    r_state   <= ST_ADDR;
                                end
                                OP_READ: begin
                                    r_is_read <= 1'b1;
                                    r_state   <= ST_ADDR;
                                end
                                OP_CLEAR: begin
                                    r_cmd_error <= 1'b0;
                                    r_state     <= ST_DISCARD;
                                end
                                default: begin
                                    r_cmd_error <= 1'b1;
                                    r_state     <= ST_DISCARD;
                                end
                            endcase
                        end
                    end

                    ST_ADDR: begin
                        if (byte_valid) begin
                            if (w_addr_oob) begin
                                r_cmd_error <= 1'b1;
                                r_state     <= ST_DISCARD;
                            end else if (r_is_read) begin
                                r_tx_byte <= w_rd_data;
                                r_tx_load <= 1'b1;
                                r_ptr     <= w_addr_idx + ADDR_W'(1);
                                r_state   <= ST_RDATA;
                            end else begin
                                r_ptr   <= w_addr_idx;
                                r_state <= ST_WDATA;
                            end
                        end
                    end

                    ST_WDATA: begin
                        if (byte_valid) begin
                            r_wr_strobe <= 1'b1;
                            r_wr_addr   <= r_ptr;
                            r_ptr       <= r_ptr + ADDR_W'(1);
                        end
                    end

                    ST_RDATA: begin
                        // Incoming byte is a dummy; only its arrival matters
                        if (byte_valid) begin
                            r_tx_byte <= w_rd_data;
                            r_tx_load <= 1'b1;
                            r_ptr     <= r_ptr + ADDR_W'(1);
                        end
                    end

                    ST_DISCARD: begin
                        r_state <= ST_DISCARD;
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_byte   = r_tx_byte;
    assign tx_load   = r_tx_load;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign busy      = (r_state != ST_IDLE);
    assign cmd_error = r_cmd_error;

endmodule : spi_reg_controller
`default_nettype wire

// File: tb/tb_spi_reg_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_reg_controller
// Description : Directed, table-driven bench for spi_reg_controller
//               (NUM_REGS=16). Each table row drives one clock cycle of
//               inputs and lists the outputs expected after that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_controller;

    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;

    logic                  clk;
    logic                  rst;
    logic                  frame_active;
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic [7:0]            tx_byte;
    logic                  tx_load;
    logic [8*NUM_REGS-1:0] regs_flat;
    logic                  wr_strobe;
    logic [ADDR_W-1:0]     wr_addr;
    logic                  busy;
    logic                  cmd_error;

    int checks   = 0;
    int failures = 0;

    spi_reg_controller #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_active (frame_active),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .tx_byte      (tx_byte),
        .tx_load      (tx_load),
        .regs_flat    (regs_flat),
        .wr_strobe    (wr_strobe),
        .wr_addr      (wr_addr),
        .busy         (busy),
        .cmd_error    (cmd_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus plus the outputs expected after the edge.
    // wa is checked only when ws=1, tb only when tl=1, reg only when ridx>=0.
    typedef struct {
        logic       fa;
        logic       bv;
        logic [7:0] b;
        logic       busy;
        logic       ws;
        logic [3:0] wa;
        logic       tl;
        logic [7:0] tb;
        logic       err;
        int         ridx;
        logic [7:0] rval;
        logic       all_zero;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx,
                       input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    function automatic logic [7:0] reg_at(input int idx);
        return regs_flat[8*idx +: 8];
    endfunction

    task automatic step(input logic fa, input logic bv, input logic [7:0] b);
        frame_active = fa;
        byte_valid   = bv;
        byte_in      = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        frame_active = 1'b0;
        byte_valid   = 1'b0;
        byte_in      = 8'h00;
        rst          = 1'b1;

        //            fa bv byte   busy ws wa    tl tb     err ridx rval   zero
        // Burst write 0x01,0x0E,AA,BB,CC with wrap to reg0
        vecs.push_back('{1, 0, 8'h00, 1, 0, 4'd0,  0, 8'h00, 0, -1, 8'h00, 0});
        vecs.push_back('{1, 1, 8'h01, 1, 0, 4'd0,  0, 8'h00, 0, -1, 8'h00, 0});
        vecs.push_back('{1, 1, 8'h0E, 1, 0, 4'd0,  0, 8'h00, 0, 14, 8'h00, 0});
        vecs.push_back('{1, 1, 8'hAA, 1, 1, 4'd14, 0, 8'h00, 0, 14, 8'hAA, 0});
        vecs.push_back('{1, 1, 8'hBB, 1, 1, 4'd15, 0, 8'h00, 0, 15, 8'hBB, 0});
        vecs.push_back('{1, 1, 8'hCC, 1, 1, 4'd0,  0, 8'h00, 0, 0,  8'hCC, 0});
        vecs.push_back('{0, 0, 8'h00, 0, 0, 4'd0,  0, 8'h00, 0, 14, 8'hAA, 0});
        // Read back 0x02,0x0F,dummy,dummy -> BB, CC, 00
        vecs.push_back('{1, 0, 8'h00, 1, 0, 4'd0,  0, 8'h00, 0, -1, 8'h00, 0});
        vecs.push_back('{1, 1, 8'h02, 1, 0, 4'd0,  0, 8'h00, 0, -1, 8'h00, 0});
        vecs.push_back('{1, 1, 8'h0F, 1, 0, 4'd0,  1, 8'hBB, 0, -1, 8'h00, 0});
        vecs.push_back('{1, 1, 8'h00, 1, 0, 4'd0,  1, 8'hCC, 0, 0,  8'hCC, 0});
        vecs.push_back('{1, 1, 8'h00, 1, 0, 4'd0,  1, 8'h00, 0, -1, 8'h00, 0});
        vecs.push_back('{0, 0, 8'h00, 0, 0, 4'd0,  0, 8'h00, 0, -1, 8'h00, 0});
        // byte_valid without chip select is ignored
        vecs.push_back('{0, 1, 8'h01, 0, 0, 4'd0,  0, 8'h00, 0, 1,  8'h00, 0});
        // Unknown opcode 0x55 then 0x01: error, no register change
        vecs.push_back('{1, 0, 8'h00, 1, 0, 4'd0,  0, 8'h00, 0, -1, 8'h00, 0});
        vecs.push_back('{1, 1, 8'h55, 1, 0, 4'd0,  0, 8'h00, 1, -1, 8'h00, 0});
        vecs.push_back('{1, 1, 8'h01, 1, 0, 4'd0,  0, 8'h00, 1, 1,  8'h00, 0});
        vecs.push_back('{0, 0, 8'h00, 0, 0, 4'd0,  0, 8'h00, 1, 0,  8'hCC, 0});
        // WRITE to out-of-range address 0x20: error stays, no strobe
        vecs.push_back('{1, 0, 8'h00, 1, 0, 4'd0,  0, 8'h00, 1, -1, 8'h00, 0});
        vecs.push_back('{1, 1, 8'h01, 1, 0, 4'd0,  0, 8'h00, 1, -1, 8'h00, 0});
        vecs.push_back('{1, 1, 8'h20, 1, 0, 4'd0,  0, 8'h00, 1, -1, 8'h00, 0});
        vecs.push_back('{1, 1, 8'hAA, 1, 0, 4'd0,  0, 8'h00, 1, 0,  8'hCC, 0});
        vecs.push_back('{0, 0, 8'h00, 0, 0, 4'd0,  0, 8'h00, 1, 15, 8'hBB, 0});
        // CLEAR: all zero, error cleared, trailing bytes discarded
        vecs.push_back('{1, 0, 8'h00, 1, 0, 4'd0,  0, 8'h00, 1, -1, 8'h00, 0});
        vecs.push_back('{1, 1, 8'h03, 1, 0, 4'd0,  0, 8'h00, 0, 14, 8'h00, 1});
        vecs.push_back('{1, 1, 8'h77, 1, 0, 4'd0,  0, 8'h00, 0, 0,  8'h00, 1});
        vecs.push_back('{0, 0, 8'h00, 0, 0, 4'd0,  0, 8'h00, 0, -1, 8'h00, 1});
        // Abort: 0x01,0x02,0x11 then CS drops with a 0x22 byte
        vecs.push_back('{1, 0, 8'h00, 1, 0, 4'd0,  0, 8'h00, 0, -1, 8'h00, 0});
        vecs.push_back('{1, 1, 8'h01, 1, 0, 4'd0,  0, 8'h00, 0, -1, 8'h00, 0});
        vecs.push_back('{1, 1, 8'h02, 1, 0, 4'd0,  0, 8'h00, 0, -1, 8'h00, 0});
        vecs.push_back('{1, 1, 8'h11, 1, 1, 4'd2,  0, 8'h00, 0, 2,  8'h11, 0});
        vecs.push_back('{0, 1, 8'h22, 0, 0, 4'd0,  0, 8'h00, 0, 3,  8'h00, 0});
        vecs.push_back('{0, 0, 8'h00, 0, 0, 4'd0,  0, 8'h00, 0, 2,  8'h11, 0});
        // Back-to-back bytes 0x01,0x00,0x01,0x02,0x03
        vecs.push_back('{1, 0, 8'h00, 1, 0, 4'd0,  0, 8'h00, 0, -1, 8'h00, 0});
        vecs.push_back('{1, 1, 8'h01, 1, 0, 4'd0,  0, 8'h00, 0, -1, 8'h00, 0});
        vecs.push_back('{1, 1, 8'h00, 1, 0, 4'd0,  0, 8'h00, 0, 0,  8'h00, 0});
        vecs.push_back('{1, 1, 8'h01, 1, 1, 4'd0,  0, 8'h00, 0, 0,  8'h01, 0});
        vecs.push_back('{1, 1, 8'h02, 1, 1, 4'd1,  0, 8'h00, 0, 1,  8'h02, 0});
        vecs.push_back('{1, 1, 8'h03, 1, 1, 4'd2,  0, 8'h00, 0, 2,  8'h03, 0});
        vecs.push_back('{0, 0, 8'h00, 0, 0, 4'd0,  0, 8'h00, 0, 1,  8'h02, 0});

        // Reset for two cycles
        repeat (2) @(posedge clk);
        #1;
        chk("reset_regs",   -1, 128'(regs_flat), 128'd0);
        chk("reset_busy",   -1, 128'(busy),      128'd0);
        chk("reset_err",    -1, 128'(cmd_error), 128'd0);
        chk("reset_tload",  -1, 128'(tx_load),   128'd0);
        chk("reset_tbyte",  -1, 128'(tx_byte),   128'd0);
        chk("reset_wstb",   -1, 128'(wr_strobe), 128'd0);
        chk("reset_waddr",  -1, 128'(wr_addr),   128'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].fa, vecs[i].bv, vecs[i].b);
            chk("busy",      i, 128'(busy),      128'(vecs[i].busy));
            chk("wr_strobe", i, 128'(wr_strobe), 128'(vecs[i].ws));
            chk("tx_load",   i, 128'(tx_load),   128'(vecs[i].tl));
            chk("cmd_error", i, 128'(cmd_error), 128'(vecs[i].err));
            if (vecs[i].ws)
                chk("wr_addr", i, 128'(wr_addr), 128'(vecs[i].wa));
            if (vecs[i].tl)
                chk("tx_byte", i, 128'(tx_byte), 128'(vecs[i].tb));
            if (vecs[i].ridx >= 0)
                chk($sformatf("reg%0d", vecs[i].ridx), i,
                    128'(reg_at(vecs[i].ridx)), 128'(vecs[i].rval));
            if (vecs[i].all_zero)
                chk("regs_all_zero", i, 128'(regs_flat), 128'd0);
        end

        // Mid-frame reset: write reg5, reset with CS held, next byte is opcode
        step(1, 0, 8'h00);
        step(1, 1, 8'h01);
        step(1, 1, 8'h05);
        step(1, 1, 8'h99);
        chk("mr_reg5", 100, 128'(reg_at(5)), 128'h99);
        rst = 1'b1;
        step(1, 0, 8'h00);
        chk("mr_regs_zero", 101, 128'(regs_flat), 128'd0);
        chk("mr_busy",      101, 128'(busy),      128'd0);
        rst = 1'b0;
        step(1, 0, 8'h00);
        chk("mr_busy_again", 102, 128'(busy), 128'd1);
        step(1, 1, 8'h55);
        chk("mr_opcode_err", 103, 128'(cmd_error), 128'd1);
        step(1, 1, 8'h07);
        chk("mr_no_write",   104, 128'(wr_strobe), 128'd0);
        step(0, 0, 8'h00);
        chk("mr_idle",       105, 128'(busy),      128'd0);

        // READ at address 0 straight after reset sees zero, wraps via ptr
        step(1, 0, 8'h00);
        step(1, 1, 8'h02);
        step(1, 1, 8'h00);
        chk("rd0_load", 106, 128'(tx_load), 128'd1);
        chk("rd0_byte", 106, 128'(tx_byte), 128'd0);
        step(1, 0, 8'h00);
        chk("rd_no_load_idle_cycle", 107, 128'(tx_load), 128'd0);
        step(0, 0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends on its own
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule : tb_spi_reg_controller
`default_nettype wire

// File: doc/spi_reg_controller.md
# spi_reg_controller

Command sequencer between the SPI slave's received-byte stream and the design's control registers. Parses chip-select-delimited frames (opcode, address, payload) and executes them:
- burst writes into an internal register bank;
- burst reads that return register bytes to the SPI slave's transmit path;
- a bank clear.

Drives a flat register bus and per-write strobes consumed by the rest of the FPGA design (LEDs, video-path configuration).

## Interface
Parameters:
- NUM_REGS, 16, number of 8-bit registers; power of two, 2..256
- ADDR_W, 4, register index width; equals log2(NUM_REGS)

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- frame_active  in  1  chip select asserted, already synchronized to clk by the SPI slave
- byte_in  in  8  received byte
- byte_valid  in  1  one-cycle pulse, byte_in valid
- tx_byte  out  8  next byte for the SPI slave to shift out
- tx_load  out  1  one-cycle pulse, tx_byte updated
- regs_flat  out  8*NUM_REGS  register bank; reg i at bits [8i+7:8i]
- wr_strobe  out  1  one-cycle pulse per register write
- wr_addr  out  ADDR_W  index written with wr_strobe
- busy  out  1  high whenever state is not IDLE
- cmd_error  out  1  sticky protocol-error flag

## Operation
- Opcodes:
  - 0x01 WRITE
  - 0x02 READ
  - 0x03 CLEAR
  - anything else is an error.
- Frame format:
  - WRITE/READ: opcode, address, then zero or more payload bytes.
  - CLEAR: opcode alone; any further bytes are discarded.
- States and transitions:
  - IDLE: wait for frame_active=1, then go to OPCODE.
  - OPCODE: next byte selects the path.
    - WRITE or READ: go to ADDR.
    - CLEAR: zero all registers, clear cmd_error, go to DISCARD.
    - Unknown opcode: set cmd_error, go to DISCARD.
  - ADDR: address byte handling.
    - Byte >= NUM_REGS: set cmd_error, go to DISCARD.
    - Otherwise latch ptr = byte[ADDR_W-1:0].
      - For WRITE, go to WDATA.
      - For READ, load tx_byte = reg[ptr], pulse tx_load, increment ptr, go to RDATA.
  - WDATA: each byte writes reg[ptr] and pulses wr_strobe with wr_addr=ptr, then ptr increments.
  - RDATA: each (dummy) byte loads tx_byte = reg[ptr] and pulses tx_load, then ptr increments. The byte value is ignored.
  - DISCARD: ignore bytes until the frame ends.
- Frame end: frame_active=0 in any state forces IDLE on the next edge. A partially received frame leaves already-written registers intact.
- byte_valid is honoured only when frame_active=1 in the same cycle.
- ptr wraps from NUM_REGS-1 to 0; no error is raised on wrap.
- cmd_error is cleared only by rst or CLEAR. Write collisions cannot occur: there is a single writer.

## Timing
- Reset values:
  - state IDLE, busy 0
  - all registers 0x00
  - tx_byte 0x00, tx_load 0
  - wr_strobe 0, wr_addr 0
  - cmd_error 0
- rst asserted mid-frame:
  - Returns to IDLE and zeroes everything.
  - After reset releases, an ongoing frame (frame_active still 1) is entered at OPCODE; its next byte is treated as the opcode.
- Latency: byte_valid at edge n gives regs_flat, wr_strobe/wr_addr, tx_byte/tx_load, and cmd_error updated at edge n+1.
- CLEAR at edge n: all registers read 0 at n+1. No wr_strobe is issued.
- busy rises one cycle after frame_active rises and falls one cycle after frame_active falls.
- Minimum byte_valid spacing supported: every cycle. No back-pressure; every qualified byte is consumed.

## Structure
- Package spi_ctrl_pkg:
  - opcode constants OP_WRITE=8'h01, OP_READ=8'h02, OP_CLEAR=8'h03;
  - state encoding constants for IDLE, OPCODE, ADDR, WDATA, RDATA, DISCARD.
- One natural sub-module, reg_bank: NUM_REGS×8 storage with one write port, synchronous clear, a combinational read mux, and the flat output.
- FSM, pointer and error logic stay in spi_reg_controller.

## Test plan
- Reset: assert rst for 2 cycles → regs_flat all 0, busy=0, cmd_error=0, tx_load=0.
- Burst write: frame 0x01,0x0E,0xAA,0xBB,0xCC with NUM_REGS=16 → reg14=0xAA, reg15=0xBB, reg0=0xCC (wrap); three wr_strobes with wr_addr 14,15,0.
- Read back: frame 0x02,0x0F,0x00,0x00 → tx_load pulses give tx_byte 0xBB, 0xCC, then reg1 (0x00).
- Errors:
  - frame 0x55,0x01 → cmd_error=1, no register change;
  - frame 0x01,0x20 → cmd_error stays 1, no wr_strobe;
  - then frame 0x03 → all regs 0, cmd_error=0.
- Abort: frame 0x01,0x02,0x11, then frame_active drops while byte_valid pulses with 0x22 in the same cycle → reg2=0x11, reg3 unchanged, busy=0 next cycle.
- Back-to-back: byte_valid on consecutive cycles for 0x01,0x00,0x01,0x02,0x03 → reg0..2 = 0x01,0x02,0x03, each visible one cycle after its byte.
